// File: rtl/df_pkg.sv
// Shared types for the reconstruction-buffer ping-pong scheduler.
package df_pkg;

    localparam int MBW_DEF = 8;
    localparam int QPW_DEF = 6;

    // Per-buffer status: written by the decoder, then owned by the filter.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        BUSY  = 2'd2
    } buf_st_t;

    // Consumer (deblocking filter) FSM.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } df_state_t;

    // Slot record layout: {mb_h, mb_v, qpy, qpc, last}.
    function automatic int slot_width(input int mbw, input int qpw);
        return 2 * mbw + 2 * qpw + 1;
    endfunction

    // Number of buffers that are not EMPTY.
    function automatic logic [1:0] occ_count(input buf_st_t a, input buf_st_t b);
        return {1'b0, a != EMPTY} + {1'b0, b != EMPTY};
    endfunction

endpackage

// File: rtl/df_mb_slot.sv
// Two-entry metadata register file: one record per reconstruction buffer.
module df_mb_slot
    import df_pkg::*;
#(
    parameter int W = slot_width(MBW_DEF, QPW_DEF)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic         wr_idx,
    input  logic [W-1:0] wr_data,
    input  logic         rd_idx,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem [2];

    // Capture the record of the MB the decoder just completed.
    // NOTE: storage has no reset; a slot is only read once its buffer status says it was written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/df_mb_pingpong_ctrl.sv
// Ping-pong scheduler between the MB decoder and the deblocking filter
// for the two reconstruction buffers (rec DF RAM0/RAM1).
module df_mb_pingpong_ctrl
    import df_pkg::*;
#(
    parameter int MBW = MBW_DEF,
    parameter int QPW = QPW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           dec_mb_done,
    input  logic [MBW-1:0] dec_mb_h,
    input  logic [MBW-1:0] dec_mb_v,
    input  logic [QPW-1:0] dec_qpy,
    input  logic [QPW-1:0] dec_qpc,
    input  logic           dec_last_mb,
    input  logic           df_mb_done,
    output logic           dec_stall,
    output logic           dec_buf_sel,
    output logic           df_start,
    output logic           df_buf_sel,
    output logic           df_busy,
    output logic [MBW-1:0] mb_num_h_DF,
    output logic [MBW-1:0] mb_num_v_DF,
    output logic [QPW-1:0] df_qpy,
    output logic [QPW-1:0] df_qpc,
    output logic           frame_done,
    output logic [1:0]     occupancy,
    output logic           proto_err
);

    localparam int SW = slot_width(MBW, QPW);

    buf_st_t   buf_st     [2];
    buf_st_t   buf_st_nxt [2];
    df_state_t state;
    logic      df_last;

    logic dec_acc;
    logic launch;
    logic release_buf;

    logic [SW-1:0]  wr_rec;
    logic [SW-1:0]  rd_rec;
    logic [MBW-1:0] rd_h;
    logic [MBW-1:0] rd_v;
    logic [QPW-1:0] rd_qpy;
    logic [QPW-1:0] rd_qpc;
    logic           rd_last;

    assign dec_stall   = (buf_st[dec_buf_sel] != EMPTY);
    assign dec_acc     = dec_mb_done && !dec_stall;
    assign launch      = (state == IDLE) && (buf_st[df_buf_sel] == FULL);
    // A done pulse coinciding with df_start cannot belong to the MB just launched.
    assign release_buf = (state == RUN) && df_mb_done && !df_start;

    assign wr_rec = {dec_mb_h, dec_mb_v, dec_qpy, dec_qpc, dec_last_mb};
    assign {rd_h, rd_v, rd_qpy, rd_qpc, rd_last} = rd_rec;

    df_mb_slot #(.W(SW)) u_slot (
        .clk     (clk),
        .wr_en   (dec_acc),
        .wr_idx  (dec_buf_sel),
        .wr_data (wr_rec),
        .rd_idx  (df_buf_sel),
        .rd_data (rd_rec)
    );

    // Next buffer status; producer and consumer updates always land on different buffers.
    always_comb begin
        // NOTE: defaults first so every path assigns every element; otherwise a latch is inferred.
        buf_st_nxt = buf_st;
        if (dec_acc) begin
            buf_st_nxt[dec_buf_sel] = FULL;
        end
        if (launch) begin
            buf_st_nxt[df_buf_sel] = BUSY;
        end
        if (release_buf) begin
            buf_st_nxt[df_buf_sel] = EMPTY;
        end
    end

    // Buffer status, pointers and consumer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_st[0]   <= EMPTY;
            buf_st[1]   <= EMPTY;
            state       <= IDLE;
            dec_buf_sel <= 1'b0;
            df_buf_sel  <= 1'b0;
            df_start    <= 1'b0;
            df_busy     <= 1'b0;
            frame_done  <= 1'b0;
            occupancy   <= 2'd0;
            proto_err   <= 1'b0;
            df_last     <= 1'b0;
            mb_num_h_DF <= '0;
            mb_num_v_DF <= '0;
            df_qpy      <= '0;
            df_qpc      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            buf_st     <= buf_st_nxt;
            occupancy  <= occ_count(buf_st_nxt[0], buf_st_nxt[1]);
            df_start   <= 1'b0;
            frame_done <= 1'b0;

            if (dec_acc) begin
                dec_buf_sel <= ~dec_buf_sel;
            end

            if ((dec_mb_done && dec_stall) || (df_mb_done && !release_buf)) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        df_start    <= 1'b1;
                        df_busy     <= 1'b1;
                        mb_num_h_DF <= rd_h;
                        mb_num_v_DF <= rd_v;
                        df_qpy      <= rd_qpy;
                        df_qpc      <= rd_qpc;
                        df_last     <= rd_last;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (release_buf) begin
                        df_busy    <= 1'b0;
                        df_buf_sel <= ~df_buf_sel;
                        frame_done <= df_last;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_df_mb_pingpong_ctrl.sv
// Scoreboard bench for the decoder/filter ping-pong scheduler.
module tb_df_mb_pingpong_ctrl;

    localparam int MBW = 8;
    localparam int QPW = 6;
    localparam int N_STREAM = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           dec_mb_done = 1'b0;
    logic [MBW-1:0] dec_mb_h = '0;
    logic [MBW-1:0] dec_mb_v = '0;
    logic [QPW-1:0] dec_qpy = '0;
    logic [QPW-1:0] dec_qpc = '0;
    logic           dec_last_mb = 1'b0;
    logic           df_mb_done = 1'b0;
    logic           dec_stall;
    logic           dec_buf_sel;
    logic           df_start;
    logic           df_buf_sel;
    logic           df_busy;
    logic [MBW-1:0] mb_num_h_DF;
    logic [MBW-1:0] mb_num_v_DF;
    logic [QPW-1:0] df_qpy;
    logic [QPW-1:0] df_qpc;
    logic           frame_done;
    logic [1:0]     occupancy;
    logic           proto_err;

    always #5 clk = ~clk;

    df_mb_pingpong_ctrl #(.MBW(MBW), .QPW(QPW)) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_mb_done (dec_mb_done),
        .dec_mb_h    (dec_mb_h),
        .dec_mb_v    (dec_mb_v),
        .dec_qpy     (dec_qpy),
        .dec_qpc     (dec_qpc),
        .dec_last_mb (dec_last_mb),
        .df_mb_done  (df_mb_done),
        .dec_stall   (dec_stall),
        .dec_buf_sel (dec_buf_sel),
        .df_start    (df_start),
        .df_buf_sel  (df_buf_sel),
        .df_busy     (df_busy),
        .mb_num_h_DF (mb_num_h_DF),
        .mb_num_v_DF (mb_num_v_DF),
        .df_qpy      (df_qpy),
        .df_qpc      (df_qpc),
        .frame_done  (frame_done),
        .occupancy   (occupancy),
        .proto_err   (proto_err)
    );

    typedef struct {
        logic           buf_idx;
        logic [MBW-1:0] h;
        logic [MBW-1:0] v;
        logic [QPW-1:0] qpy;
        logic [QPW-1:0] qpc;
        logic           last;
    } exp_rec_t;

    exp_rec_t sb [$];
    int       n_vec  = 0;
    int       n_miss = 0;
    logic     exp_dec_sel = 1'b0;
    logic     cur_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decoder completes one MB; accepted MBs are pushed onto the scoreboard.
    task automatic dec_mb(input logic [MBW-1:0] h, input logic [MBW-1:0] v,
                          input logic [QPW-1:0] qy, input logic [QPW-1:0] qc,
                          input logic last, input logic accept);
        dec_mb_h    = h;
        dec_mb_v    = v;
        dec_qpy     = qy;
        dec_qpc     = qc;
        dec_last_mb = last;
        dec_mb_done = 1'b1;
        if (accept) begin
            sb.push_back('{exp_dec_sel, h, v, qy, qc, last});
            exp_dec_sel = ~exp_dec_sel;
        end
        tick();
        dec_mb_done = 1'b0;
    endtask

    task automatic df_done();
        df_mb_done = 1'b1;
        tick();
        df_mb_done = 1'b0;
    endtask

    // Decoder and filter complete in the same cycle.
    task automatic both_done(input logic [MBW-1:0] h, input logic [MBW-1:0] v,
                             input logic [QPW-1:0] qy, input logic [QPW-1:0] qc);
        df_mb_done = 1'b1;
        dec_mb(h, v, qy, qc, 1'b0, 1'b1);
        df_mb_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  dec_stall, 0);
        check({tag, "_dsel"},   dec_buf_sel, 0);
        check({tag, "_start"},  df_start, 0);
        check({tag, "_fsel"},   df_buf_sel, 0);
        check({tag, "_busy"},   df_busy, 0);
        check({tag, "_h"},      mb_num_h_DF, 0);
        check({tag, "_v"},      mb_num_v_DF, 0);
        check({tag, "_qpy"},    df_qpy, 0);
        check({tag, "_qpc"},    df_qpc, 0);
        check({tag, "_fdone"},  frame_done, 0);
        check({tag, "_occ"},    occupancy, 0);
        check({tag, "_perr"},   proto_err, 0);
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        dec_mb_done = 1'b0;
        df_mb_done  = 1'b0;
        tick();
        check_all_zero(tag);
        reset = 1'b0;
        sb.delete();
        exp_dec_sel = 1'b0;
    endtask

    // Scoreboard: every df_start must match the oldest accepted MB.
    always @(negedge clk) begin : sb_monitor
        exp_rec_t e;
        if (df_start === 1'b1) begin
            if (sb.size() == 0) begin
                check("start_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_buf", df_buf_sel, e.buf_idx);
                check("sb_h",   mb_num_h_DF, e.h);
                check("sb_v",   mb_num_v_DF, e.v);
                check("sb_qpy", df_qpy, e.qpy);
                check("sb_qpc", df_qpc, e.qpc);
                check("sb_busy", df_busy, 1);
                cur_last = e.last;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset("rst0");

        // Single MB, last of picture.
        dec_mb(8'd3, 8'd5, 6'd28, 6'd29, 1'b1, 1'b1);
        check("s1_occ_full", occupancy, 1);
        check("s1_dsel", dec_buf_sel, 1);
        check("s1_no_start_yet", df_start, 0);
        check("s1_stall", dec_stall, 0);
        tick();
        check("s1_start", df_start, 1);
        check("s1_fsel", df_buf_sel, 0);
        check("s1_h", mb_num_h_DF, 3);
        check("s1_v", mb_num_v_DF, 5);
        tick();
        check("s1_start_pulse", df_start, 0);
        repeat (6) tick();
        df_done();
        check("s1_frame_done", frame_done, 1);
        check("s1_occ_empty", occupancy, 0);
        check("s1_busy_off", df_busy, 0);
        check("s1_fsel_toggle", df_buf_sel, 1);
        tick();
        check("s1_frame_pulse", frame_done, 0);
        check("s1_h_held", mb_num_h_DF, 3);
        check("s1_perr", proto_err, 0);

        // Ping-pong fill, then a stalled write.
        dec_mb(8'd10, 8'd1, 6'd20, 6'd21, 1'b0, 1'b1);
        check("s2_dsel0", dec_buf_sel, 0);
        tick();
        dec_mb(8'd11, 8'd1, 6'd22, 6'd23, 1'b0, 1'b1);
        check("s2_dsel1", dec_buf_sel, 1);
        check("s2_occ2", occupancy, 2);
        check("s2_stall", dec_stall, 1);
        dec_mb(8'd99, 8'd99, 6'd1, 6'd1, 1'b1, 1'b0);
        check("s2_perr", proto_err, 1);
        check("s2_occ_kept", occupancy, 2);
        check("s2_dsel_kept", dec_buf_sel, 1);
        repeat (3) tick();
        check("s2_perr_sticky", proto_err, 1);
        df_done();
        check("s2_stall_drop", dec_stall, 0);
        check("s2_occ1", occupancy, 1);
        check("s2_no_bypass_start", df_start, 0);
        check("s2_no_frame", frame_done, 0);
        tick();
        check("s2_start2", df_start, 1);
        check("s2_h2", mb_num_h_DF, 11);
        tick();

        // Simultaneous decoder and filter completion.
        both_done(8'd12, 8'd2, 6'd30, 6'd31);
        check("s3_occ", occupancy, 1);
        check("s3_busy_off", df_busy, 0);
        check("s3_dsel", dec_buf_sel, 0);
        check("s3_fsel", df_buf_sel, 1);
        tick();
        check("s3_start", df_start, 1);
        check("s3_h", mb_num_h_DF, 12);
        check("s3_occ_busy", occupancy, 1);

        // Reset while running with both buffers occupied.
        dec_mb(8'd13, 8'd2, 6'd32, 6'd33, 1'b0, 1'b1);
        check("s4_occ2", occupancy, 2);
        do_reset("s4_rst");

        // Spurious filter done while idle.
        df_done();
        check("s5_no_frame", frame_done, 0);
        check("s5_perr", proto_err, 1);
        check("s5_fsel", df_buf_sel, 0);
        check("s5_dsel", dec_buf_sel, 0);
        check("s5_occ", occupancy, 0);
        do_reset("s5_rst");

        // Single MB again after reset.
        dec_mb(8'd3, 8'd5, 6'd28, 6'd29, 1'b1, 1'b1);
        tick();
        check("s6_start", df_start, 1);
        check("s6_fsel", df_buf_sel, 0);
        tick();
        df_done();
        check("s6_frame_done", frame_done, 1);
        check("s6_occ", occupancy, 0);

        // Stream of MBs with random decoder gaps and filter latencies.
        fork
            begin : dec_proc
                for (int i = 0; i < N_STREAM; i++) begin
                    int w;
                    w = 0;
                    while (dec_stall && w < 60) begin
                        tick();
                        w++;
                    end
                    if (w >= 60) check("stream_stall_timeout", 1, 0);
                    dec_mb(8'(i + 20), 8'(i + 40), 6'(i + 10), 6'(i + 11),
                           (i == 4) || (i == N_STREAM - 1), 1'b1);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin : df_proc
                for (int j = 0; j < N_STREAM; j++) begin
                    int w;
                    w = 0;
                    while (df_start !== 1'b1 && w < 60) begin
                        tick();
                        w++;
                    end
                    if (w >= 60) check("stream_start_timeout", 1, 0);
                    repeat ($urandom_range(1, 4)) tick();
                    df_done();
                    check("stream_frame_done", frame_done, cur_last);
                    check("stream_busy_off", df_busy, 0);
                end
            end
        join
        tick();
        check("stream_sb_empty", sb.size(), 0);
        check("stream_occ", occupancy, 0);
        check("stream_perr", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/df_mb_pingpong_ctrl.md
Name: df_mb_pingpong_ctrl

Overview:
- Scheduler for the two 128-bit reconstruction buffers (rec DF RAM0/RAM1) between the MB decoder (producer) and the deblocking filter (consumer).
- The decoder fills one buffer while the filter drains the other.
- Per buffer, the block latches MB coordinates, QPs and a last-MB flag, launches the filter with a start pulse, and stalls the decoder when no empty buffer is available.

Parameters:
MBW, 8, width of MB horizontal/vertical index
QPW, 6, width of QPy/QPc

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dec_mb_done  in  1  pulse; decoder finished writing current MB into buffer dec_buf_sel (end_of_MB_DEC)
dec_mb_h  in  MBW  MB column of the MB being completed
dec_mb_v  in  MBW  MB row of the MB being completed
dec_qpy  in  QPW  luma QP of that MB
dec_qpc  in  QPW  chroma QP of that MB
dec_last_mb  in  1  qualifies dec_mb_done: last MB of picture
df_mb_done  in  1  pulse; filter finished the MB in buffer df_buf_sel (end_of_MB_DF)
dec_stall  out  1  decoder must not start/complete an MB
dec_buf_sel  out  1  buffer index the decoder writes (0=RAM0, 1=RAM1)
df_start  out  1  one-cycle pulse launching the filter on buffer df_buf_sel
df_buf_sel  out  1  buffer index the filter reads
df_busy  out  1  filter owns a buffer
mb_num_h_DF  out  MBW  latched MB column for the running filter MB
mb_num_v_DF  out  MBW  latched MB row for the running filter MB
df_qpy  out  QPW  latched QPy for the running filter MB
df_qpc  out  QPW  latched QPc for the running filter MB
frame_done  out  1  one-cycle pulse when the last MB of the picture finishes filtering
occupancy  out  2  number of buffers FULL or BUSY (0..2)
proto_err  out  1  sticky; set on a protocol violation

Behaviour:
- Buffer status: each buffer buf_st[i] is one of EMPTY, FULL (decoded, awaiting filter) or BUSY (filter running).
- Reset (synchronous, active-high):
  - buf_st = EMPTY for both buffers; dec_buf_sel = 0; df_buf_sel = 0.
  - Consumer FSM = IDLE.
  - All outputs 0: dec_stall, df_start, df_busy, frame_done, occupancy, proto_err, latched MB fields.
  - Reset asserted mid-MB aborts everything; no pulse is emitted in the reset cycle.
- dec_stall (combinational) = (buf_st[dec_buf_sel] != EMPTY).
- Producer side, on dec_mb_done with dec_stall=0, on the next edge:
  - buf_st[dec_buf_sel] <= FULL.
  - Store h, v, qpy, qpc and last into slot dec_buf_sel.
  - Toggle dec_buf_sel.
- Producer violation: dec_mb_done while dec_stall=1 is ignored and sets proto_err.
- Consumer FSM states: IDLE, RUN.
  - IDLE: if buf_st[df_buf_sel]==FULL, then next edge: df_start=1 for exactly one cycle, buf_st <= BUSY, copy slot fields to the mb_num_*_DF/df_qp* registers, state <= RUN.
    - A buffer that turns FULL at edge N produces df_start at edge N+1, i.e. minimum latency 1 cycle.
  - RUN: df_busy=1. On df_mb_done, next edge:
    - buf_st[df_buf_sel] <= EMPTY; toggle df_buf_sel; state <= IDLE.
    - If the slot's last flag is set, frame_done=1 for one cycle.
    - The next df_start is at the earliest the edge after that, giving a minimum 1-cycle gap between MBs.
  - df_mb_done in IDLE is ignored and sets proto_err.
  - df_start and df_mb_done in the same cycle: df_mb_done is treated as a violation.
- Latched fields: mb_num_*_DF and df_qp* hold their values after RUN exits, until the next df_start.
- Simultaneous events: dec_mb_done and df_mb_done in the same cycle are both applied. They always target different buffers, except when both buffers are busy, in which case dec_mb_done is blocked by the stall.
- Buffer release: a buffer released by df_mb_done at edge N is visible as EMPTY at N+1, so dec_stall drops in cycle N+1 (no same-cycle bypass).
- occupancy: registered count of non-EMPTY buffers, updated on the same edge as buf_st.
- Ordering: MBs are filtered strictly in decode order; the two pointers alternate 0,1,0,1.
- Last-MB handling: the last flag does not block further decoding. The next picture's MBs may enter the free buffer before frame_done.

Decomposition:
- Shared package df_pkg:
  - Buffer status encoding: EMPTY=2'd0, FULL=2'd1, BUSY=2'd2.
  - Consumer FSM encoding: IDLE, RUN.
  - Slot record width: 2*MBW + 2*QPW + 1.
- Natural sub-module: df_mb_slot, a 2-entry metadata register file with write index/read index. The FSM and pointers stay in the top module.

Test Plan:
- Single MB: dec_mb_done with h=3, v=5, qpy=28, qpc=29, last=1 at cycle 10 -> df_start at 11, df_buf_sel=0, mb_num_h_DF=3, mb_num_v_DF=5; df_mb_done at 20 -> frame_done at 21, occupancy back to 0 at 21.
- Ping-pong: dec_mb_done at 10 and 12, no df_mb_done -> dec_buf_sel goes 0→1→0, occupancy=2, dec_stall=1 from cycle 13; df_mb_done at 30 -> dec_stall=0 at 31, second df_start at 32 with df_buf_sel=1.
- Stalled write: with both buffers non-EMPTY, pulse dec_mb_done -> buffer state unchanged, proto_err=1 and stays 1 until reset.
- Simultaneous: buf0 BUSY, buf1 EMPTY; dec_mb_done and df_mb_done in the same cycle -> buf1 FULL, buf0 EMPTY, df_start on buf1 one cycle later, occupancy=1.
- Spurious done: df_mb_done while IDLE -> no frame_done, proto_err=1, pointers unchanged.
- Reset mid-RUN: assert reset during RUN with occupancy=2 -> next cycle all outputs 0, both pointers 0; a subsequent dec_mb_done behaves as in the single-MB scenario.
